// File: rtl/fetch_queue.sv
// fetch_queue: receiving end of the 2-wide fetch interface.
// A DEPTH-entry circular buffer that accepts up to two {addr, instr} pairs
// per cycle from fetch and presents the two oldest entries to decode in
// program order (show-ahead), with backpressure and a priority flush.
module fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic [1:0]              in_valid_i,
  input  logic [ADDR_WIDTH-1:0]   in_addr_0_i,
  input  logic [DATA_WIDTH-1:0]   in_instr_0_i,
  input  logic [ADDR_WIDTH-1:0]   in_addr_1_i,
  input  logic [DATA_WIDTH-1:0]   in_instr_1_i,
  output logic                    in_ready_o,
  output logic [1:0]              out_valid_o,
  output logic [ADDR_WIDTH-1:0]   out_addr_0_o,
  output logic [DATA_WIDTH-1:0]   out_instr_0_o,
  output logic [ADDR_WIDTH-1:0]   out_addr_1_o,
  output logic [DATA_WIDTH-1:0]   out_instr_1_o,
  input  logic [1:0]              out_accept_i,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Highest occupancy at which a full pair is still guaranteed to fit.
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  // Number of set bits in a 2-bit slot mask.
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    popcount2 = {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

  logic [ADDR_WIDTH-1:0] addr_mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic                  in_ready_s;
  logic                  enq_ok_s;
  logic [1:0]            enq_n_s;
  logic [1:0]            deq_n_s;
  logic [1:0]            out_valid_s;
  logic                  wa_en_s, wb_en_s;
  logic [PTR_W-1:0]      wa_ptr_s, wb_ptr_s;
  logic [ADDR_WIDTH-1:0] wa_addr_s, wb_addr_s;
  logic [DATA_WIDTH-1:0] wa_instr_s, wb_instr_s;
  logic [PTR_W-1:0]      head_p1_s;

  // Backpressure, occupancy flags and dequeue amount from registered state.
  always_comb begin
    in_ready_s     = (count_q <= READY_MAX);
    out_valid_s[0] = (count_q >= CNT_W'(1));
    out_valid_s[1] = (count_q >= CNT_W'(2));
    head_p1_s      = head_q + PTR_W'(1);
    // Accept beyond what is presented is ignored; a lone bit1 means nothing.
    if ((out_accept_i == 2'b11) && (out_valid_s == 2'b11)) begin
      deq_n_s = 2'd2;
    end else if (out_accept_i[0] && out_valid_s[0]) begin
      deq_n_s = 2'd1;
    end else begin
      deq_n_s = 2'd0;
    end
  end

  // Compact the valid input slots onto two write ports at tail and tail+1.
  always_comb begin
    enq_ok_s   = in_ready_s && !flush_i;
    wa_en_s    = 1'b0;
    wb_en_s    = 1'b0;
    wa_ptr_s   = tail_q;
    wb_ptr_s   = tail_q + PTR_W'(1);
    wa_addr_s  = in_addr_0_i;
    wa_instr_s = in_instr_0_i;
    wb_addr_s  = in_addr_1_i;
    wb_instr_s = in_instr_1_i;
    case (in_valid_i)
      2'b01: begin
        wa_en_s = enq_ok_s;
      end
      2'b10: begin
        // Only the younger slot is valid: it becomes the next entry.
        wa_en_s    = enq_ok_s;
        wa_addr_s  = in_addr_1_i;
        wa_instr_s = in_instr_1_i;
      end
      2'b11: begin
        wa_en_s = enq_ok_s;
        wb_en_s = enq_ok_s;
      end
      default: begin
        wa_en_s = 1'b0;
        wb_en_s = 1'b0;
      end
    endcase
    if (enq_ok_s) begin
      enq_n_s = popcount2(in_valid_i);
    end else begin
      enq_n_s = 2'd0;
    end
  end

  // Pointer and occupancy update; flush overrides enqueue and dequeue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_n_s);
      tail_d  = tail_q + PTR_W'(enq_n_s);
      count_d = count_q + CNT_W'(enq_n_s) - CNT_W'(deq_n_s);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wa_en_s) begin
      addr_mem_q[wa_ptr_s]  <= wa_addr_s;
      instr_mem_q[wa_ptr_s] <= wa_instr_s;
    end
    if (wb_en_s) begin
      addr_mem_q[wb_ptr_s]  <= wb_addr_s;
      instr_mem_q[wb_ptr_s] <= wb_instr_s;
    end
  end

  assign in_ready_o    = in_ready_s;
  assign out_valid_o   = out_valid_s;
  assign out_addr_0_o  = addr_mem_q[head_q];
  assign out_instr_0_o = instr_mem_q[head_q];
  assign out_addr_1_o  = addr_mem_q[head_p1_s];
  assign out_instr_1_o = instr_mem_q[head_p1_s];
  assign count_o       = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run, all compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] i;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [1:0]    in_valid = 2'b00;
  logic [AW-1:0] in_addr_0 = '0, in_addr_1 = '0;
  logic [DW-1:0] in_instr_0 = '0, in_instr_1 = '0;
  logic          in_ready;
  logic [1:0]    out_valid;
  logic [AW-1:0] out_addr_0, out_addr_1;
  logic [DW-1:0] out_instr_0, out_instr_1;
  logic [1:0]    out_accept = 2'b00;
  logic [3:0]    count;

  int checks = 0;
  int failures = 0;
  ent_t q[$];

  fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_addr_0_i(in_addr_0), .in_instr_0_i(in_instr_0),
    .in_addr_1_i(in_addr_1), .in_instr_1_i(in_instr_1),
    .in_ready_o(in_ready), .out_valid_o(out_valid),
    .out_addr_0_o(out_addr_0), .out_instr_0_o(out_instr_0),
    .out_addr_1_o(out_addr_1), .out_instr_1_o(out_instr_1),
    .out_accept_i(out_accept), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic fl, input logic [1:0] v,
                       input logic [AW-1:0] a0, input logic [DW-1:0] i0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] i1,
                       input logic [1:0] acc);
    flush = fl; in_valid = v; out_accept = acc;
    in_addr_0 = a0; in_instr_0 = i0; in_addr_1 = a1; in_instr_1 = i1;
  endtask

  // Advance the reference model by one edge using the current inputs,
  // then move to the next falling edge where outputs are sampled.
  task automatic tick();
    int sz;
    int n;
    sz = q.size();
    if (flush) begin
      q.delete();
    end else begin
      if (out_accept == 2'b11 && sz >= 2) n = 2;
      else if (out_accept[0] && sz >= 1) n = 1;
      else n = 0;
      for (int k = 0; k < n; k++) q.delete(0);
      if (sz <= DEPTH - 2) begin
        if (in_valid[0]) q.push_back('{a: in_addr_0, i: in_instr_0});
        if (in_valid[1]) q.push_back('{a: in_addr_1, i: in_instr_1});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, '0, '0, '0, '0, 2'b00);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL reset_out_valid got=%b exp=00", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    rst = 1'b0;
    q.delete();
    idle();
    repeat (3) tick();
    checks++; if (count !== 4'd0 || out_valid !== 2'b00) begin failures++; $display("FAIL reset_hold count=%0d out_valid=%b exp=0/00", count, out_valid); end
  endtask

  task automatic test_single_pair();
    drive(1'b0, 2'b11, 32'h0, 32'h13, 32'h4, 32'h93, 2'b00);
    tick();
    idle();
    checks++; if (out_valid !== 2'b11) begin failures++; $display("FAIL pair_out_valid got=%b exp=11", out_valid); end
    checks++; if (out_addr_0 !== 32'h0 || out_addr_1 !== 32'h4) begin failures++; $display("FAIL pair_addr got=%h/%h exp=0/4", out_addr_0, out_addr_1); end
    checks++; if (out_instr_0 !== 32'h13 || out_instr_1 !== 32'h93) begin failures++; $display("FAIL pair_instr got=%h/%h exp=13/93", out_instr_0, out_instr_1); end
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL pair_count got=%0d exp=2", count); end
  endtask

  task automatic test_fill();
    logic [3:0] exp_cnt;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 2'b11, 32'(8 * k), 32'(k), 32'(8 * k + 4), 32'(k + 100), 2'b00);
      tick();
      exp_cnt = 4'(2 + 2 * k);
      checks++; if (count !== exp_cnt) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count, exp_cnt); end
      checks++; if (in_ready !== (exp_cnt <= 4'd6)) begin failures++; $display("FAIL fill_in_ready got=%b at count=%0d", in_ready, exp_cnt); end
    end
    drive(1'b0, 2'b11, 32'hDEAD, 32'h1, 32'hBEEF, 32'h2, 2'b00);
    tick();
    idle();
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL fill_drop_count got=%0d exp=8", count); end
    checks++; if (out_addr_0 !== 32'h0 || q.size() != 8) begin failures++; $display("FAIL fill_drop_head got=%h exp=0", out_addr_0); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] nxt;
    logic [AW-1:0] exp_next;
    int pushed;
    int popped;
    int n;
    drive(1'b1, 2'b00, '0, '0, '0, '0, 2'b00);
    tick();
    nxt = '0; exp_next = '0; pushed = 0; popped = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 20) drive(1'b0, 2'b11, nxt, ~nxt, nxt + 32'd4, ~(nxt + 32'd4), 2'b11);
      else drive(1'b0, 2'b00, '0, '0, '0, '0, 2'b11);
      n = (q.size() >= 2) ? 2 : q.size();
      if (n >= 1) begin
        checks++; if (out_addr_0 !== exp_next || out_instr_0 !== ~exp_next) begin failures++; $display("FAIL wrap_order0 got=%h exp=%h", out_addr_0, exp_next); end
      end
      if (n == 2) begin
        checks++; if (out_addr_1 !== exp_next + 32'd4) begin failures++; $display("FAIL wrap_order1 got=%h exp=%h", out_addr_1, exp_next + 32'd4); end
      end
      exp_next = exp_next + 32'(4 * n);
      popped = popped + n;
      if (c < 20 && q.size() <= DEPTH - 2) begin
        nxt = nxt + 32'd8;
        pushed = pushed + 2;
      end
      tick();
    end
    idle();
    checks++; if (popped != pushed || count !== 4'd0) begin failures++; $display("FAIL wrap_total popped=%0d pushed=%0d count=%0d", popped, pushed, count); end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 2'b00, '0, '0, '0, '0, 2'b00);
    tick();
    drive(1'b0, 2'b11, 32'h40, 32'h1, 32'h44, 32'h2, 2'b00);
    tick();
    drive(1'b0, 2'b01, 32'h48, 32'h3, 32'h0, 32'h0, 2'b00);
    tick();
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL simul_pre_count got=%0d exp=3", count); end
    drive(1'b0, 2'b11, 32'h4C, 32'h4, 32'h50, 32'h5, 2'b01);
    tick();
    idle();
    checks++; if (count !== 4'd4) begin failures++; $display("FAIL simul_count got=%0d exp=4", count); end
    checks++; if (out_addr_0 !== 32'h44) begin failures++; $display("FAIL simul_head got=%h exp=44", out_addr_0); end
  endtask

  task automatic test_flush();
    drive(1'b1, 2'b00, '0, '0, '0, '0, 2'b00);
    tick();
    drive(1'b0, 2'b11, 32'h10, 32'h1, 32'h14, 32'h2, 2'b00); tick();
    drive(1'b0, 2'b11, 32'h18, 32'h3, 32'h1C, 32'h4, 2'b00); tick();
    drive(1'b0, 2'b01, 32'h20, 32'h5, 32'h0, 32'h0, 2'b00); tick();
    drive(1'b1, 2'b11, 32'h30, 32'h6, 32'h34, 32'h7, 2'b11);
    checks++; if (count !== 4'd5 || out_valid !== 2'b11) begin failures++; $display("FAIL flush_pre count=%0d out_valid=%b exp=5/11", count, out_valid); end
    tick();
    checks++; if (count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_post count=%0d out_valid=%b in_ready=%b", count, out_valid, in_ready); end
    drive(1'b0, 2'b01, 32'h100, 32'h77, 32'h0, 32'h0, 2'b00);
    tick();
    idle();
    checks++; if (out_addr_0 !== 32'h100 || out_valid !== 2'b01) begin failures++; $display("FAIL flush_refill addr=%h out_valid=%b exp=100/01", out_addr_0, out_valid); end
  endtask

  task automatic test_odd();
    drive(1'b1, 2'b00, '0, '0, '0, '0, 2'b00);
    tick();
    drive(1'b0, 2'b10, 32'hAAA, 32'h1, 32'h200, 32'h22, 2'b00);
    tick();
    checks++; if (count !== 4'd1 || out_addr_0 !== 32'h200 || out_instr_0 !== 32'h22) begin failures++; $display("FAIL odd_slot1 count=%0d addr=%h exp=1/200", count, out_addr_0); end
    drive(1'b0, 2'b11, 32'h204, 32'h3, 32'h208, 32'h4, 2'b00);
    tick();
    drive(1'b0, 2'b00, '0, '0, '0, '0, 2'b10);
    tick();
    checks++; if (count !== 4'd3 || out_addr_0 !== 32'h200) begin failures++; $display("FAIL odd_accept10 count=%0d addr=%h exp=3/200", count, out_addr_0); end
    drive(1'b0, 2'b00, '0, '0, '0, '0, 2'b01); tick();
    drive(1'b0, 2'b00, '0, '0, '0, '0, 2'b01); tick();
    drive(1'b0, 2'b00, '0, '0, '0, '0, 2'b11); tick();
    idle();
    checks++; if (count !== 4'd0 || out_valid !== 2'b00) begin failures++; $display("FAIL odd_over_accept count=%0d out_valid=%b exp=0/00", count, out_valid); end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 2'b11, 32'h500, 32'h1, 32'h504, 32'h2, 2'b00);
    tick();
    idle();
    #2 rst = 1'b1;
    #1;
    q.delete();
    checks++; if (count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin failures++; $display("FAIL reset_mid count=%0d out_valid=%b in_ready=%b", count, out_valid, in_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] nxt;
    logic [1:0]    pv;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] i0, i1;
    bit            have;
    bit            taken;
    int            sz;
    nxt = 32'h1000; have = 0; pv = 2'b00; a0 = '0; a1 = '0; i0 = '0; i1 = '0;
    for (int c = 0; c < 400; c++) begin
      if (!have) begin
        pv = 2'($urandom_range(0, 3));
        a0 = $urandom; a1 = $urandom; i0 = $urandom; i1 = $urandom;
        if (pv[0]) begin a0 = nxt; nxt = nxt + 32'd4; end
        if (pv[1]) begin a1 = nxt; nxt = nxt + 32'd4; end
        have = 1;
      end
      drive(($urandom_range(0, 15) == 0), pv, a0, i0, a1, i1, 2'($urandom_range(0, 3)));
      sz = q.size();
      checks++; if (count !== 4'(sz)) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, count, sz); end
      checks++; if (out_valid !== {sz >= 2, sz >= 1} || in_ready !== (sz <= DEPTH - 2)) begin failures++; $display("FAIL rand_flags cyc=%0d out_valid=%b in_ready=%b size=%0d", c, out_valid, in_ready, sz); end
      if (sz >= 1) begin
        checks++; if (out_addr_0 !== q[0].a || out_instr_0 !== q[0].i) begin failures++; $display("FAIL rand_slot0 cyc=%0d got=%h/%h exp=%h/%h", c, out_addr_0, out_instr_0, q[0].a, q[0].i); end
      end
      if (sz >= 2) begin
        checks++; if (out_addr_1 !== q[1].a || out_instr_1 !== q[1].i) begin failures++; $display("FAIL rand_slot1 cyc=%0d got=%h/%h exp=%h/%h", c, out_addr_1, out_instr_1, q[1].a, q[1].i); end
      end
      taken = flush || (sz <= DEPTH - 2);
      tick();
      if (taken) have = 0;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_odd();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
